regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
//
// PURPOSE
//   Parametrised MIPS-style register file: configurable width and depth,
//   2 asynchronous read ports, 2 synchronous write ports (A, B).
//   Adds optional write-to-read bypass, an optional hard-zero register 0,
//   async reset, and a sequenced bulk-clear engine (one register per cycle).
//   Drop-in for the CPU decode stage; port B is the second retire path.
//
// PARAMETERS
//   WIDTH     32  data bits per register
//   ADDR_W    5   address bits; DEPTH = 2**ADDR_W registers (localparam)
//   ZERO_REG  1   1: reg[0] reads 0 and ignores writes; 0: reg[0] is ordinary
//   BYPASS    1   1: same-cycle write data forwarded to reads; 0: reads show stored value
//
// PORTS
//   Clk             in   1       clock, positive-edge
//   Reset           in   1       async, active-high; clears all state
//   RegWriteA       in   1       write enable, port A
//   WriteRegisterA  in   ADDR_W  write address, port A
//   WriteDataA      in   WIDTH   write data, port A
//   RegWriteB       in   1       write enable, port B
//   WriteRegisterB  in   ADDR_W  write address, port B
//   WriteDataB      in   WIDTH   write data, port B
//   ReadRegister1   in   ADDR_W  read address, port 1
//   ReadRegister2   in   ADDR_W  read address, port 2
//   ReadData1       out  WIDTH   read data, port 1 (combinational)
//   ReadData2       out  WIDTH   read data, port 2 (combinational)
//   Clear           in   1       bulk-clear request, sampled at posedge
//   Busy            out  1       high while bulk clear in progress
//
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high.
//   - Reset: all DEPTH registers <= 0, FSM -> IDLE, clear counter <= 0,
//     Busy = 0. ReadData1/2 = 0 while Reset is held (all regs 0, no writes).
//   - Write: at posedge, if RegWriteX && !Busy, reg[WriteRegisterX] <= WriteDataX.
//     A and B to the same address in the same cycle: B wins.
//     ZERO_REG=1: writes to address 0 dropped on both ports.
//   - Read: ReadDataN = reg[ReadRegisterN], asynchronous, zero-cycle latency.
//     ZERO_REG=1 and address 0: ReadDataN = 0 always (bypass never applies).
//     BYPASS=1: if a write is accepted this cycle to ReadRegisterN, ReadDataN
//     = that write's data (B over A); otherwise stored value.
//   - FSM states: IDLE, CLEARING.
//     IDLE: Busy=0. Clear=1 at posedge -> CLEARING, counter <= 0.
//     CLEARING: Busy=1. Each posedge: reg[counter] <= 0, counter += 1.
//       At counter == DEPTH-1, the edge clears the last register and
//       returns to IDLE, counter <= 0.
//     Timing: Clear sampled at edge N -> Busy high after N; reg[i] zeroed at
//       edge N+1+i; Busy low after edge N+DEPTH (DEPTH cycles busy).
//   - While Busy: all writes dropped (no bypass, no store); Clear ignored;
//     reads return current stored contents (mix of cleared/uncleared).
//   - Clear and write in the same IDLE cycle: write stored at that edge,
//     then erased by the sweep.
//   - Reset asserted mid-CLEARING: immediate IDLE, Busy=0, all regs 0.
//   - Counter is ADDR_W bits; terminal check at DEPTH-1, no wrap beyond.
//
// TESTING
//   1. Reset, read all 32 addrs on both ports -> 0; Busy=0.
//   2. A writes 0xDEADBEEF to r5, B writes 0x12345678 to r5 same edge;
//      read r5 -> 0x12345678; during that cycle, BYPASS=1 -> read r5 shows
//      0x12345678 before the edge.
//   3. Write 0xFFFFFFFF to r0 (ZERO_REG=1) -> r0 reads 0; repeat with
//      ZERO_REG=0 -> r0 reads 0xFFFFFFFF.
//   4. Fill r1..r31 with 0x100+i, pulse Clear -> Busy high exactly 32 cycles;
//      r3 reads 0x103 until edge N+4, then 0; all regs 0 after Busy falls.
//   5. During CLEARING, write 0xAAAA5555 to r31 and pulse Clear again ->
//      write dropped, Busy still falls at N+32, r31 reads 0.
//   6. Assert Reset at cycle 10 of a clear -> Busy=0 immediately, all regs 0;
//      new write to r7 = 0x77 after release reads back 0x77.

Source files
------------

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file: two async read ports, two sync write ports,
// optional write bypass and hard-zero r0, plus a one-register-per-cycle bulk clear engine.
module regfile_multiport #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RegWriteA,
    input  logic [ADDR_W-1:0] WriteRegisterA,
    input  logic [WIDTH-1:0]  WriteDataA,
    input  logic              RegWriteB,
    input  logic [ADDR_W-1:0] WriteRegisterB,
    input  logic [WIDTH-1:0]  WriteDataB,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    input  logic              Clear,
    output logic              Busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t            state;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic [ADDR_W-1:0] clearCount;
    logic              busyReg;
    logic              acceptA;
    logic              acceptB;

    // A write is accepted only when idle, out of reset, and not aimed at a hard-zero r0.
    always_comb begin
        acceptA = RegWriteA && !busyReg && !Reset;
        acceptB = RegWriteB && !busyReg && !Reset;
        if (ZERO_REG != 0 && WriteRegisterA == '0) acceptA = 1'b0;
        if (ZERO_REG != 0 && WriteRegisterB == '0) acceptB = 1'b0;
    end

    always_comb begin
        ReadData1 = regs[ReadRegister1];
        if (BYPASS != 0 && acceptA && WriteRegisterA == ReadRegister1) ReadData1 = WriteDataA;
        if (BYPASS != 0 && acceptB && WriteRegisterB == ReadRegister1) ReadData1 = WriteDataB;
        if (ZERO_REG != 0 && ReadRegister1 == '0) ReadData1 = '0;
    end

    always_comb begin
        ReadData2 = regs[ReadRegister2];
        if (BYPASS != 0 && acceptA && WriteRegisterA == ReadRegister2) ReadData2 = WriteDataA;
        if (BYPASS != 0 && acceptB && WriteRegisterB == ReadRegister2) ReadData2 = WriteDataB;
        if (ZERO_REG != 0 && ReadRegister2 == '0) ReadData2 = '0;
    end

    // Port B is written after port A so it wins on an address collision.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            state      <= IDLE;
            clearCount <= '0;
            busyReg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acceptA) regs[WriteRegisterA] <= WriteDataA;
                    if (acceptB) regs[WriteRegisterB] <= WriteDataB;
                    if (Clear) begin
                        state      <= CLEARING;
                        clearCount <= '0;
                        busyReg    <= 1'b1;
                    end
                end
                CLEARING: begin
                    regs[clearCount] <= '0;
                    if (clearCount == LAST_ADDR) begin
                        state      <= IDLE;
                        clearCount <= '0;
                        busyReg    <= 1'b0;
                    end else begin
                        clearCount <= clearCount + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busyReg;

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: vector table for read/write/bypass behaviour,
// hand-written sequences for the bulk clear, writes during clear and reset mid-clear.
module tb_regfile_multiport;

    typedef struct {
        logic        weA;
        logic [4:0]  waA;
        logic [31:0] wdA;
        logic        weB;
        logic [4:0]  waB;
        logic [31:0] wdB;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        regWriteA = 1'b0;
    logic [4:0]  writeRegisterA = '0;
    logic [31:0] writeDataA = '0;
    logic        regWriteB = 1'b0;
    logic [4:0]  writeRegisterB = '0;
    logic [31:0] writeDataB = '0;
    logic [4:0]  readRegister1 = '0;
    logic [4:0]  readRegister2 = '0;
    logic        clear = 1'b0;
    logic [31:0] readData1, readData2, readData1Nz, readData2Nz;
    logic        busy, busyNz;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    regfile_multiport #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .Clk(clk), .Reset(reset),
        .RegWriteA(regWriteA), .WriteRegisterA(writeRegisterA), .WriteDataA(writeDataA),
        .RegWriteB(regWriteB), .WriteRegisterB(writeRegisterB), .WriteDataB(writeDataB),
        .ReadRegister1(readRegister1), .ReadRegister2(readRegister2),
        .ReadData1(readData1), .ReadData2(readData2),
        .Clear(clear), .Busy(busy)
    );

    regfile_multiport #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) dutNoZero (
        .Clk(clk), .Reset(reset),
        .RegWriteA(regWriteA), .WriteRegisterA(writeRegisterA), .WriteDataA(writeDataA),
        .RegWriteB(regWriteB), .WriteRegisterB(writeRegisterB), .WriteDataB(writeDataB),
        .ReadRegister1(readRegister1), .ReadRegister2(readRegister2),
        .ReadData1(readData1Nz), .ReadData2(readData2Nz),
        .Clear(clear), .Busy(busyNz)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
        end
    endtask

    task automatic expectNow(input string name, input logic [31:0] e1, input logic [31:0] e2,
                             input logic eb);
        exp_t e;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        e.eb   = eb;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        regWriteA      = v.weA;
        writeRegisterA = v.waA;
        writeDataA     = v.wdA;
        regWriteB      = v.weB;
        writeRegisterB = v.waB;
        writeDataB     = v.wdB;
        readRegister1  = v.rr1;
        readRegister2  = v.rr2;
        expectNow(name, v.exp1, v.exp2, 1'b0);
    endtask

    task automatic checkOutput();
        exp_t e;
        #2;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: queue empty, got 0x%08h, expected an entry", readData1);
        end else begin
            e = expQ.pop_front();
            check({e.name, ".rd1"}, readData1, e.e1);
            check({e.name, ".rd2"}, readData2, e.e2);
            check({e.name, ".busy"}, {31'b0, busy}, {31'b0, e.eb});
        end
    endtask

    task automatic idleInputs();
        regWriteA = 1'b0;
        regWriteB = 1'b0;
        clear     = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'h12345678, 5'd5, 5'd6, 32'h12345678, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 32'h12345678, 32'h0};
        vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 32'h0, 32'h12345678};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0};
        vecs[4] = '{1'b1, 5'd9, 32'hA9, 1'b1, 5'd10, 32'hB10, 5'd9, 5'd10, 32'hA9, 32'hB10};
        vecs[5] = '{1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10, 32'h99, 32'hB10};
        vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10, 32'h99, 32'hB10};
        vecs[7] = '{1'b1, 5'd11, 32'h11, 1'b0, 5'd0, 32'h0, 5'd11, 5'd12, 32'h11, 32'h0};
        vecs[8] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h13, 5'd0, 5'd13, 32'h0, 32'h13};

        // Reset held: every address reads zero even with a write request pending.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            regWriteA      = 1'b1;
            writeRegisterA = 5'(i);
            writeDataA     = 32'hC0DE0000 + 32'(i);
            readRegister1  = 5'(i);
            readRegister2  = 5'(31 - i);
            expectNow($sformatf("reset.addr%0d", i), 32'h0, 32'h0, 1'b0);
            checkOutput();
        end
        check("reset.busyNoZero", {31'b0, busyNz}, 32'h0);
        @(negedge clk);
        idleInputs();
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            checkOutput();
        end

        // Ordinary r0 keeps the value written by vec2.
        @(negedge clk);
        idleInputs();
        readRegister1 = 5'd0;
        readRegister2 = 5'd5;
        #2;
        check("noZero.r0", readData1Nz, 32'hFFFFFFFF);
        check("noZero.r5", readData2Nz, 32'h12345678);
        check("zero.r0", readData1, 32'h0);

        // Fill, then sweep: watch r3, r31 and Busy edge by edge.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            regWriteA      = 1'b1;
            writeRegisterA = 5'(i);
            writeDataA     = 32'h100 + 32'(i);
        end
        @(negedge clk);
        regWriteA     = 1'b0;
        clear         = 1'b1;
        readRegister1 = 5'd3;
        readRegister2 = 5'd31;
        expectNow("clr.req", 32'h103, 32'h11F, 1'b0);
        checkOutput();
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 1) clear = 1'b0;
            expectNow($sformatf("clr.k%0d", k), (k >= 5) ? 32'h0 : 32'h103,
                      (k >= 33) ? 32'h0 : 32'h11F, k <= 32);
            checkOutput();
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            readRegister1 = 5'(i);
            readRegister2 = 5'(i);
            expectNow($sformatf("clr.after%0d", i), 32'h0, 32'h0, 1'b0);
            checkOutput();
        end

        // Write and a second Clear during the sweep are both ignored.
        @(negedge clk);
        regWriteA      = 1'b1;
        writeRegisterA = 5'd31;
        writeDataA     = 32'h1F;
        @(negedge clk);
        regWriteA     = 1'b0;
        clear         = 1'b1;
        readRegister1 = 5'd31;
        readRegister2 = 5'd3;
        expectNow("busyWr.req", 32'h1F, 32'h0, 1'b0);
        checkOutput();
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 1) clear = 1'b0;
            if (k == 10) begin
                regWriteA      = 1'b1;
                writeRegisterA = 5'd31;
                writeDataA     = 32'hAAAA5555;
                clear          = 1'b1;
            end
            if (k == 11) idleInputs();
            expectNow($sformatf("busyWr.k%0d", k), (k >= 33) ? 32'h0 : 32'h1F, 32'h0, k <= 32);
            checkOutput();
        end

        // Reset in the middle of a sweep.
        @(negedge clk);
        regWriteA      = 1'b1;
        writeRegisterA = 5'd7;
        writeDataA     = 32'h7;
        @(negedge clk);
        writeRegisterA = 5'd20;
        writeDataA     = 32'h20;
        @(negedge clk);
        regWriteA     = 1'b0;
        clear         = 1'b1;
        readRegister1 = 5'd7;
        readRegister2 = 5'd20;
        expectNow("rstClr.req", 32'h7, 32'h20, 1'b0);
        checkOutput();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) clear = 1'b0;
            expectNow($sformatf("rstClr.k%0d", k), (k >= 9) ? 32'h0 : 32'h7, 32'h20, 1'b1);
            checkOutput();
        end
        reset = 1'b1;
        expectNow("rstClr.inReset", 32'h0, 32'h0, 1'b0);
        checkOutput();
        @(negedge clk);
        reset          = 1'b0;
        regWriteA      = 1'b1;
        writeRegisterA = 5'd7;
        writeDataA     = 32'h77;
        expectNow("rstClr.bypass77", 32'h77, 32'h0, 1'b0);
        checkOutput();
        @(negedge clk);
        regWriteA = 1'b0;
        expectNow("rstClr.stored77", 32'h77, 32'h0, 1'b0);
        checkOutput();
        @(negedge clk);
        expectNow("rstClr.idle", 32'h77, 32'h0, 1'b0);
        checkOutput();

        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: %0d entries left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
